// File: rtl/pll_lock_sequencer.sv
// Reset/lock sequencer for the refclk-driven PLL: holds PLL reset, qualifies lock, retries, flags fault.
// Optional feature: define PLL_SEQ_LOSS_CNT_EN to add the saturating RUN lock-loss counter (loss_cnt_o).
module pll_lock_sequencer #(
    parameter int unsigned RST_HOLD_CYC     = 16,
    parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
    parameter int unsigned SETTLE_CYC       = 1024,
    parameter int unsigned MAX_RETRY        = 3,
    parameter int unsigned CNT_W            = 17
) (
    input  logic                             refclk,
    input  logic                             rst_n,
    input  logic                             restart_i,
    input  logic                             pll_locked_i,
    output logic                             pll_rst_o,
    output logic                             pll_ready_o,
    output logic                             fault_o,
    output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt_o,
    output logic [2:0]                       state_o
`ifdef PLL_SEQ_LOSS_CNT_EN
    ,
    output logic [7:0]                       loss_cnt_o
`endif
);

    localparam int unsigned RW = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [RW-1:0]    RETRY_LAST   = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        WAIT_LOCK = 3'd1,
        SETTLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] timer, timer_nxt;
    logic [RW-1:0]    retry_nxt;
    logic             lock_meta, lock_s;
    logic             attempt_fail;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked_i;
            lock_s    <= lock_meta;
        end
    end

    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer + 1'b1;
        retry_nxt    = retry_cnt_o;
        attempt_fail = 1'b0;
        if (restart_i) begin
            state_nxt = HOLD;
            timer_nxt = '0;
            retry_nxt = '0;
        end else begin
            case (state)
                HOLD: begin
                    if (timer == HOLD_LAST) state_nxt = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (lock_s)                     state_nxt    = SETTLE;
                    else if (timer == TIMEOUT_LAST) attempt_fail = 1'b1;
                end
                SETTLE: begin
                    if (!lock_s) begin
                        attempt_fail = 1'b1;
                    end else if (timer == SETTLE_LAST) begin
                        state_nxt = RUN;
                        retry_nxt = '0;
                    end
                end
                RUN: begin
                    if (!lock_s) state_nxt = HOLD;
                end
                FAULT: ;
                default: state_nxt = HOLD;
            endcase
            if (attempt_fail) begin
                if (retry_cnt_o == RETRY_LAST) begin
                    state_nxt = FAULT;
                end else begin
                    retry_nxt = retry_cnt_o + 1'b1;
                    state_nxt = HOLD;
                end
            end
            if (state_nxt != state) timer_nxt = '0;
        end
    end

    // Outputs are registered off the next state so they change on the same edge as the state.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HOLD;
            timer       <= '0;
            retry_cnt_o <= '0;
            pll_rst_o   <= 1'b1;
            pll_ready_o <= 1'b0;
            fault_o     <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            retry_cnt_o <= retry_nxt;
            pll_rst_o   <= (state_nxt == HOLD) || (state_nxt == FAULT);
            pll_ready_o <= (state_nxt == RUN);
            fault_o     <= (state_nxt == FAULT);
        end
    end

    assign state_o = state;

`ifdef PLL_SEQ_LOSS_CNT_EN
    // Only genuine lock losses in RUN count; a coincident restart takes precedence.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt_o <= '0;
        end else if (!restart_i && state == RUN && !lock_s && loss_cnt_o != 8'hFF) begin
            loss_cnt_o <= loss_cnt_o + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed scenarios plus random lock/restart traffic
// checked every cycle against a cycle-count reference model with a queue-based lock delay.
module tb_pll_lock_sequencer;

    localparam int unsigned HOLD_C = 4;
    localparam int unsigned TO_C   = 20;
    localparam int unsigned SET_C  = 8;
    localparam int unsigned MAXR   = 2;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       restart_i;
    logic       pll_locked_i;
    logic       pll_rst_o;
    logic       pll_ready_o;
    logic       fault_o;
    logic [1:0] retry_cnt_o;
    logic [2:0] state_o;
`ifdef PLL_SEQ_LOSS_CNT_EN
    logic [7:0] loss_cnt_o;
`endif

    always #5 refclk = ~refclk;

    pll_lock_sequencer #(
        .RST_HOLD_CYC     (HOLD_C),
        .LOCK_TIMEOUT_CYC (TO_C),
        .SETTLE_CYC       (SET_C),
        .MAX_RETRY        (MAXR),
        .CNT_W            (5)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .restart_i    (restart_i),
        .pll_locked_i (pll_locked_i),
        .pll_rst_o    (pll_rst_o),
        .pll_ready_o  (pll_ready_o),
        .fault_o      (fault_o),
        .retry_cnt_o  (retry_cnt_o),
        .state_o      (state_o)
`ifdef PLL_SEQ_LOSS_CNT_EN
        ,
        .loss_cnt_o   (loss_cnt_o)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference model: phase number, cycles spent in phase, retries, losses.
    int m_state, m_elapsed, m_retry, m_loss;
    bit hist[$];

    function automatic void model_reset();
        m_state = 0; m_elapsed = 0; m_retry = 0; m_loss = 0;
        hist = {1'b0, 1'b0};
    endfunction

    function automatic void go(input int s);
        m_state   = s;
        m_elapsed = 0;
    endfunction

    function automatic void model_step(input bit lk, input bit rs);
        bit seen;
        bit fail;
        seen = hist.pop_front();
        hist.push_back(lk);
        if (rs) begin
            go(0);
            m_retry = 0;
            return;
        end
        m_elapsed++;
        fail = 1'b0;
        case (m_state)
            0: if (m_elapsed == HOLD_C) go(1);
            1: begin
                if (seen) go(2);
                else if (m_elapsed == TO_C) fail = 1'b1;
            end
            2: begin
                if (!seen) fail = 1'b1;
                else if (m_elapsed == SET_C) begin go(3); m_retry = 0; end
            end
            3: begin
                if (!seen) begin
                    go(0);
                    if (m_loss < 255) m_loss++;
                end
            end
            default: ;
        endcase
        if (fail) begin
            if (m_retry == MAXR) go(4);
            else begin m_retry++; go(0); end
        end
    endfunction

    task automatic compare_all();
        check("state", state_o, m_state);
        check("pll_rst", pll_rst_o, (m_state == 0) || (m_state == 4));
        check("ready", pll_ready_o, m_state == 3);
        check("fault", fault_o, m_state == 4);
        check("retry", retry_cnt_o, m_retry);
`ifdef PLL_SEQ_LOSS_CNT_EN
        check("loss", loss_cnt_o, m_loss);
`endif
    endtask

    task automatic tick(input bit lk, input bit rs);
        pll_locked_i = lk;
        restart_i    = rs;
        @(posedge refclk);
        model_step(lk, rs);
        @(negedge refclk);
        restart_i = 1'b0;
        compare_all();
    endtask

    task automatic wait_state(input int target, input int budget, input bit lk, input string tag);
        int n;
        n = 0;
        while (state_o != target && n < budget) begin
            tick(lk, 1'b0);
            n++;
        end
        check(tag, state_o, target);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, state_o, 0);
        check({tag, "_pll_rst"}, pll_rst_o, 1);
        check({tag, "_ready"}, pll_ready_o, 0);
        check({tag, "_fault"}, fault_o, 0);
        check({tag, "_retry"}, retry_cnt_o, 0);
`ifdef PLL_SEQ_LOSS_CNT_EN
        check({tag, "_loss"}, loss_cnt_o, 0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int run_left;
        bit lk;
        bit rs;

        rst_n = 1'b0; restart_i = 1'b0; pll_locked_i = 1'b0;
        model_reset();
        repeat (3) @(negedge refclk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // 1: clean lock sequence
        n = 0;
        while (pll_rst_o && n < 50) begin tick(1'b0, 1'b0); n++; end
        check("t1_hold_cycles", n, HOLD_C);
        n = 0;
        while (!pll_ready_o && n < 50) begin tick(1'b1, 1'b0); n++; end
        check("t1_ready_latency", n, SET_C + 3);
        check("t1_retry", retry_cnt_o, 0);

        // 2: lock never arrives -> fault
        tick(1'b0, 1'b1);
        n = 0;
        while (state_o != 3'd4 && n < 200) begin tick(1'b0, 1'b0); n++; end
        check("t2_fault_cycles", n, (MAXR + 1) * (HOLD_C + TO_C));
        repeat (30) tick(1'b0, 1'b0);
        check("t2_fault_held", fault_o, 1);
        check("t2_retry", retry_cnt_o, MAXR);
        check("t2_pll_rst", pll_rst_o, 1);
        check("t2_ready", pll_ready_o, 0);

        // 5a: restart out of fault
        tick(1'b0, 1'b1);
        check("t5_fault_clear", fault_o, 0);
        check("t5_state_hold", state_o, 0);
        wait_state(3, 100, 1'b1, "t5_reach_run");

        // 3: one-cycle lock glitch during SETTLE
        tick(1'b1, 1'b1);
        wait_state(2, 50, 1'b1, "t3_reach_settle");
        repeat (4) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        wait_state(0, 20, 1'b1, "t3_back_to_hold");
        check("t3_retry_one", retry_cnt_o, 1);
        wait_state(3, 100, 1'b1, "t3_reach_run");
        check("t3_retry_zero", retry_cnt_o, 0);

        // 4: lock loss in RUN
        n = 0;
        while (pll_ready_o && n < 20) begin tick(1'b0, 1'b0); n++; end
        check("t4_ready_fall", n, 3);
        check("t4_state", state_o, 0);
        check("t4_retry", retry_cnt_o, 0);
`ifdef PLL_SEQ_LOSS_CNT_EN
        check("t4_loss_one", loss_cnt_o, 1);
`endif

        // 5b: restart coincident with the final SETTLE cycle
        tick(1'b1, 1'b1);
        wait_state(2, 50, 1'b1, "t5b_reach_settle");
        repeat (SET_C - 1) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        check("t5b_state_hold", state_o, 0);
        check("t5b_not_ready", pll_ready_o, 0);

        // 6: async reset mid-SETTLE
        wait_state(2, 50, 1'b1, "t6_reach_settle");
        repeat (3) tick(1'b1, 1'b0);
        @(posedge refclk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("t6_async");
        model_reset();
        @(negedge refclk);
        pll_locked_i = 1'b0;
        rst_n = 1'b1;

        // random traffic
        run_left = 0;
        lk = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (run_left == 0) begin
                lk = ($urandom_range(0, 1) == 1);
                run_left = lk ? $urandom_range(1, 40) : $urandom_range(1, 90);
            end
            run_left--;
            rs = ($urandom_range(0, 99) == 0);
            tick(lk, rs);
        end

`ifdef PLL_SEQ_LOSS_CNT_EN
        tick(1'b1, 1'b1);
        for (int i = 0; i < 256; i++) begin
            wait_state(3, 100, 1'b1, "sat_reach_run");
            repeat (3) tick(1'b0, 1'b0);
        end
        check("loss_saturated", loss_cnt_o, 255);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
